idelay_ctrl: RTL and testbench

- Behavioural/synthesizable model of the IDELAY calibration controller.
- Clocked by the reference clock, MCLK in the DDR2 top level; reset by the inverse of PLL lock.
- Asserts RDY once the delay taps are calibrated. RDY gates the system reset (Reset = ResetIn | ~pllLock | ~RDY), so the DDR controller and tester start only after calibration.

---
 rtl/idelay_ctrl_pkg.sv | 21 ++
 rtl/idelay_ctrl_rst_sync.sv | 30 +++
 rtl/idelay_ctrl.sv | 115 +++++++++++
 tb/tb_idelay_ctrl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/idelay_ctrl_pkg.sv
// Shared types, default parameters and counter sizing for the IDELAY calibration controller.
package idelay_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CAL   = 2'd1,
    READY = 2'd2
  } state_e;

  localparam int DEF_LOCK_CYCLES  = 64;
  localparam int DEF_SYNC_STAGES  = 2;
  localparam int DEF_RECAL_PERIOD = 1024;

  // One counter covers both the lock count and the recalibration interval.
  function automatic int cnt_width(input int a, input int b);
    int m;
    m = (a > b) ? a : b;
    return (m <= 2) ? 1 : $clog2(m);
  endfunction

endpackage

// File: rtl/idelay_ctrl_rst_sync.sv
// Reset synchronizer: asserts asynchronously, releases after SYNC_STAGES clock edges.
module rst_sync
  import idelay_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic clk,
  input  logic rst,
  output logic rst_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], 1'b0};
  end

  // Written as "if (!rst)" so an unknown reset level falls into the reset branch.
  always_ff @(posedge clk or posedge rst) begin
    if (!rst) begin
      sync_q <= sync_d;
    end else begin
      sync_q <= '1;
    end
  end

  assign rst_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/idelay_ctrl.sv
// IDELAY calibration controller: raises RDY SYNC_STAGES+LOCK_CYCLES edges after reset release.
// Optional maintenance strobe on RECAL_PULSE enabled by defining IDELAYCTRL_RECAL_EN.
module idelay_ctrl
  import idelay_ctrl_pkg::*;
#(
  parameter int LOCK_CYCLES  = DEF_LOCK_CYCLES,
  parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
  parameter int RECAL_PERIOD = DEF_RECAL_PERIOD
) (
  input  logic REFCLK,
  input  logic RST,
  output logic RDY,
  output logic CAL_BUSY,
  output logic RECAL_PULSE
);

  localparam int CNT_W = cnt_width(LOCK_CYCLES, RECAL_PERIOD);
  localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_CYCLES - 1);

  logic rst_i;

  rst_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_rst_sync (
    .clk  (REFCLK),
    .rst  (RST),
    .rst_o(rst_i)
  );

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] cnt_inc;
  logic             rdy_q, rdy_d;
  logic             cal_busy_q, cal_busy_d;

  assign cnt_inc = cnt_q + 1'b1;

  always_ff @(posedge REFCLK or posedge rst_i) begin
    if (!rst_i) begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdy_q      <= rdy_d;
      cal_busy_q <= cal_busy_d;
    end else begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdy_q      <= 1'b0;
      cal_busy_q <= 1'b0;
    end
  end

`ifdef IDELAYCTRL_RECAL_EN
  localparam logic [CNT_W-1:0] RECAL_LAST = CNT_W'(RECAL_PERIOD - 1);
`endif

  // The transition fires on the edge where the count reaches LOCK_CYCLES-1,
  // so the IDLE edge plus LOCK_CYCLES-1 CAL edges give LOCK_CYCLES in total.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        state_d = CAL;
        cnt_d   = '0;
      end
      CAL: begin
        cnt_d = cnt_inc;
        if (cnt_inc == LOCK_LAST) begin
          state_d = READY;
          cnt_d   = '0;
        end
      end
      READY: begin
`ifdef IDELAYCTRL_RECAL_EN
        cnt_d = (cnt_q == RECAL_LAST) ? '0 : cnt_inc;
`else
        cnt_d = cnt_q;
`endif
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    rdy_d      = (state_d == READY);
    cal_busy_d = (state_d == CAL);
  end

`ifdef IDELAYCTRL_RECAL_EN
  logic recal_q, recal_d;

  always_comb begin
    recal_d = (state_q == READY) && (cnt_q == RECAL_LAST);
  end

  always_ff @(posedge REFCLK or posedge rst_i) begin
    if (!rst_i) begin
      recal_q <= recal_d;
    end else begin
      recal_q <= 1'b0;
    end
  end

  assign RECAL_PULSE = recal_q;
`else
  assign RECAL_PULSE = 1'b0;
`endif

  assign RDY      = rdy_q;
  assign CAL_BUSY = cal_busy_q;

endmodule

// File: tb/tb_idelay_ctrl.sv
// Directed bench for idelay_ctrl: default instance plus a LOCK_CYCLES=4/SYNC_STAGES=3 instance.
`timescale 1ns/1ps
module tb_idelay_ctrl;

  logic REFCLK;
  logic RST;
  logic rdy, cal_busy, recal;
  logic rdy_ov, cal_busy_ov, recal_ov;

  int compared;
  int mismatched;

  idelay_ctrl #(
    .LOCK_CYCLES (64),
    .SYNC_STAGES (2),
    .RECAL_PERIOD(16)
  ) dut (
    .REFCLK     (REFCLK),
    .RST        (RST),
    .RDY        (rdy),
    .CAL_BUSY   (cal_busy),
    .RECAL_PULSE(recal)
  );

  idelay_ctrl #(
    .LOCK_CYCLES (4),
    .SYNC_STAGES (3),
    .RECAL_PERIOD(16)
  ) dut_ov (
    .REFCLK     (REFCLK),
    .RST        (RST),
    .RDY        (rdy_ov),
    .CAL_BUSY   (cal_busy_ov),
    .RECAL_PULSE(recal_ov)
  );

  initial REFCLK = 1'b0;
  always #5 REFCLK = ~REFCLK;

  task automatic check(input string tag, input logic observed, input logic expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("FAIL %s observed=%0b expected=%0b", tag, observed, expected);
    end
  endtask

  // Advance n rising edges and land 1 ns after the last one.
  task automatic edges(input int n);
    repeat (n) @(posedge REFCLK);
    #1;
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    // Power-up
    RST = 1'b1;
    edges(10);
    check("rst_rdy", rdy, 1'b0);
    check("rst_busy", cal_busy, 1'b0);
    check("rst_recal", recal, 1'b0);
    check("rst_rdy_ov", rdy_ov, 1'b0);
    @(negedge REFCLK) RST = 1'b0;
    edges(2);
    check("pu_e2_busy", cal_busy, 1'b0);
    edges(1);
    check("pu_e3_busy", cal_busy, 1'b1);
    check("pu_e3_rdy", rdy, 1'b0);
    check("ov_e3_busy", cal_busy_ov, 1'b0);
    edges(1);
    check("ov_e4_busy", cal_busy_ov, 1'b1);
    edges(2);
    check("ov_e6_rdy", rdy_ov, 1'b0);
    edges(1);
    check("ov_e7_rdy", rdy_ov, 1'b1);
    check("ov_e7_busy", cal_busy_ov, 1'b0);
    edges(58);
    check("pu_e65_rdy", rdy, 1'b0);
    check("pu_e65_busy", cal_busy, 1'b1);
    edges(1);
    check("pu_e66_rdy", rdy, 1'b1);
    check("pu_e66_busy", cal_busy, 1'b0);

`ifdef IDELAYCTRL_RECAL_EN
    edges(15);
    check("recal_15", recal, 1'b0);
    edges(1);
    check("recal_16", recal, 1'b1);
    edges(1);
    check("recal_17", recal, 1'b0);
    edges(15);
    check("recal_32", recal, 1'b1);
    edges(1);
    check("recal_33", recal, 1'b0);
    edges(15);
    check("recal_48", recal, 1'b1);
    check("recal_rdy", rdy, 1'b1);
`else
    for (int i = 0; i < 2000; i++) begin
      edges(1);
      check("norecal", recal, 1'b0);
    end
    check("norecal_rdy", rdy, 1'b1);
`endif

    // Reset mid-calibration
    @(negedge REFCLK) RST = 1'b1;
    #1;
    check("mid_rst_rdy", rdy, 1'b0);
    edges(2);
    check("mid_rst_busy", cal_busy, 1'b0);
    @(negedge REFCLK) RST = 1'b0;
    edges(30);
    check("mid_e30_busy", cal_busy, 1'b1);
    check("mid_e30_rdy", rdy, 1'b0);
    @(negedge REFCLK) RST = 1'b1;
    edges(1);
    check("mid_abort_busy", cal_busy, 1'b0);
    check("mid_abort_rdy", rdy, 1'b0);
    @(negedge REFCLK) RST = 1'b0;
    edges(65);
    check("mid_e65_rdy", rdy, 1'b0);
    edges(1);
    check("mid_e66_rdy", rdy, 1'b1);

    // Short asynchronous pulse between edges while READY
    check("async_pre_ov", rdy_ov, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("async_drop", rdy, 1'b0);
    check("async_drop_ov", rdy_ov, 1'b0);
    #1 RST = 1'b0;
    edges(6);
    check("async_ov_e6", rdy_ov, 1'b0);
    edges(1);
    check("async_ov_e7", rdy_ov, 1'b1);
    edges(58);
    check("async_e65_rdy", rdy, 1'b0);
    edges(1);
    check("async_e66_rdy", rdy, 1'b1);
    check("async_e66_busy", cal_busy, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
